// File: rtl/reg_writeback_queue_pkg.sv
// Shared definitions for the register-file write-side front end.
// The architectural widths and the hard-wired zero register are defined here and reused by decode and the register file.
package reg_writeback_queue_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_DATA_W = 32;
  localparam int WB_REG_AW = 5;
  localparam logic [WB_REG_AW-1:0] WB_ZERO_REG = '0;

  // Source of the value loaded into the write port on a given cycle.
  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_MD
  } wb_src_e;

endpackage

// File: rtl/reg_writeback_queue_if.sv
// Bundle of result producers, decode scoreboard queries and the register file write port.
interface reg_writeback_queue_if
  import reg_writeback_queue_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = WB_REG_AW
) ();

  logic              alu_valid;
  logic [REG_AW-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              md_valid;
  logic [REG_AW-1:0] md_reg;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;
  logic [REG_AW-1:0] query_reg1;
  logic [REG_AW-1:0] query_reg2;
  logic              pending1;
  logic              pending2;
  logic              regWrite;
  logic [REG_AW-1:0] writeReg;
  logic [DATA_W-1:0] writeData;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output md_valid, md_reg, md_data,
    output query_reg1, query_reg2,
    input  md_ready, pending1, pending2,
    input  regWrite, writeReg, writeData
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  md_valid, md_reg, md_data,
    input  query_reg1, query_reg2,
    output md_ready, pending1, pending2,
    output regWrite, writeReg, writeData
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer for MUL/DIV results, with a per-entry live bit that a younger write can clear.
// Each entry also reports whether it is a live write to either of the two decode query registers.
module wb_fifo
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = WB_REG_AW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [REG_AW-1:0] i_push_reg,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_kill_en,
  input  logic [REG_AW-1:0] i_kill_reg,
  input  logic [REG_AW-1:0] i_query1,
  input  logic [REG_AW-1:0] i_query2,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_head_live,
  output logic [REG_AW-1:0] o_head_reg,
  output logic [DATA_W-1:0] o_head_data,
  output logic [DEPTH-1:0]  o_match1,
  output logic [DEPTH-1:0]  o_match2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  r_live;
  logic [REG_AW-1:0] r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign w_push_ok   = i_push && !o_full;
  assign w_pop_ok    = i_pop && !o_empty;
  assign o_head_live = r_live[r_rd_ptr];
  assign o_head_reg  = r_reg[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];

  // Free slots keep live=0, so the live bit alone marks an in-flight write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_live   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i_kill_en && (r_reg[i] == i_kill_reg)) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_pop_ok) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + PW'(1);
      end
      if (w_push_ok) begin
        r_live[r_wr_ptr] <= !(i_kill_en && (i_kill_reg == i_push_reg));
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_reg[r_wr_ptr]  <= i_push_reg;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  always_comb begin
    o_match1 = '0;
    o_match2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_match1[i] = r_live[i] && (r_reg[i] == i_query1);
      o_match2[i] = r_live[i] && (r_reg[i] == i_query2);
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Write-side front end of the register file: arbitrates ALU and queued MUL/DIV results onto one
// registered write port and reports in-flight writes to decode.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = WB_REG_AW
) (
  input logic               clock_in,
  input logic               reset,
  reg_writeback_queue_if.slave bus
);

  localparam logic [REG_AW-1:0] ZERO = REG_AW'(WB_ZERO_REG);

  logic              w_alu_win;
  logic              w_md_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_head_live;
  logic [REG_AW-1:0] w_head_reg;
  logic [DATA_W-1:0] w_head_data;
  logic [DEPTH-1:0]  w_match1;
  logic [DEPTH-1:0]  w_match2;
  wb_src_e           w_src;

  logic              r_regWrite;
  logic [REG_AW-1:0] r_writeReg;
  logic [DATA_W-1:0] r_writeData;

  assign w_alu_win  = bus.alu_valid && (bus.alu_reg != ZERO);
  assign w_md_ready = !reset && !w_full;
  // A push to the zero register completes its handshake but is never stored.
  assign w_push     = bus.md_valid && w_md_ready && (bus.md_reg != ZERO);
  assign w_pop      = !reset && !w_alu_win && !w_empty;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fifo (
    .i_clk       (clock_in),
    .i_rst       (reset),
    .i_push      (w_push),
    .i_push_reg  (bus.md_reg),
    .i_push_data (bus.md_data),
    .i_pop       (w_pop),
    .i_kill_en   (w_alu_win),
    .i_kill_reg  (bus.alu_reg),
    .i_query1    (bus.query_reg1),
    .i_query2    (bus.query_reg2),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_live (w_head_live),
    .o_head_reg  (w_head_reg),
    .o_head_data (w_head_data),
    .o_match1    (w_match1),
    .o_match2    (w_match2)
  );

  always_comb begin
    w_src = WB_SRC_NONE;
    if (w_alu_win) begin
      w_src = WB_SRC_ALU;
    end else if (w_pop) begin
      w_src = WB_SRC_MD;
    end
  end

  // A killed head is still popped, but leaves regWrite low.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_regWrite  <= 1'b0;
      r_writeReg  <= '0;
      r_writeData <= '0;
    end else begin
      case (w_src)
        WB_SRC_ALU: begin
          r_regWrite  <= 1'b1;
          r_writeReg  <= bus.alu_reg;
          r_writeData <= bus.alu_data;
        end
        WB_SRC_MD: begin
          r_regWrite  <= w_head_live && (w_head_reg != ZERO);
          r_writeReg  <= w_head_reg;
          r_writeData <= w_head_data;
        end
        default: r_regWrite <= 1'b0;
      endcase
    end
  end

  assign bus.md_ready  = w_md_ready;
  assign bus.regWrite  = r_regWrite;
  assign bus.writeReg  = r_writeReg;
  assign bus.writeData = r_writeData;
  assign bus.pending1  = !reset && (bus.query_reg1 != ZERO) &&
                         ((|w_match1) || (r_regWrite && (r_writeReg == bus.query_reg1)));
  assign bus.pending2  = !reset && (bus.query_reg2 != ZERO) &&
                         ((|w_match2) || (r_regWrite && (r_writeReg == bus.query_reg2)));

endmodule
